// File: rtl/pc_branch_unit.sv
// Fetch-side PC stage: holds PC, selects next PC from PC+4, branch, jump or a buffered redirect.
// Optional J / JR support is compiled in with `define PC_JUMP_EN.
module pc_branch_unit #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_8000
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Stall,
    input  logic        BranchTaken,
    input  logic [31:0] SignExtImm,
    input  logic [31:0] PCPlus4_ID,
    input  logic        Jump,
    input  logic [25:0] JumpIdx,
    input  logic        JumpReg,
    input  logic [31:0] RegTarget,
    output logic [31:0] PC,
    output logic [31:0] PCPlus4,
    output logic        RedirPending,
    output logic        AddrErr,
    output logic [31:0] FetchCount
);

    typedef enum logic [0:0] {StRun, StHold} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_tgt_q;
    logic        pend_jr_q;
    logic        redir_q;
    logic        addr_err_q;
    logic [31:0] fetch_count_q;

    logic [31:0] br_target;
    logic        req_valid;
    logic        req_jr;
    logic [31:0] req_tgt;

    logic [31:0] apply_tgt;
    logic        apply_jr;
    logic        apply_misaligned;
    logic [31:0] next_pc;

    // Offset is in words; the top two immediate bits shift out.
    assign br_target = PCPlus4_ID + {SignExtImm[29:0], 2'b00};

    logic unused_imm_hi;
    assign unused_imm_hi = ^SignExtImm[31:30];

`ifdef PC_JUMP_EN
    logic [31:0] j_target;
    assign j_target = {PCPlus4_ID[31:28], JumpIdx, 2'b00};

    // Same-cycle priority: JumpReg > Jump > BranchTaken.
    always_comb begin
        req_valid = JumpReg | Jump | BranchTaken;
        req_jr    = JumpReg;
        if (JumpReg) begin
            req_tgt = RegTarget;
        end else if (Jump) begin
            req_tgt = j_target;
        end else begin
            req_tgt = br_target;
        end
    end
`else
    logic unused_jump;
    assign unused_jump = ^{Jump, JumpIdx, JumpReg, RegTarget};

    assign req_valid = BranchTaken;
    assign req_jr    = 1'b0;
    assign req_tgt   = br_target;
`endif

    assign PCPlus4 = pc_q + 32'd4;

    // A fresh request beats a buffered one; JR alignment is checked when applied.
    always_comb begin
        apply_tgt = PCPlus4;
        apply_jr  = 1'b0;
        if (req_valid) begin
            apply_tgt = req_tgt;
            apply_jr  = req_jr;
        end else if (state_q == StHold) begin
            apply_tgt = pend_tgt_q;
            apply_jr  = pend_jr_q;
        end
        apply_misaligned = apply_jr && (apply_tgt[1:0] != 2'b00);
        next_pc          = apply_misaligned ? EXC_VEC : apply_tgt;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q       <= StRun;
            pc_q          <= RESET_VEC;
            pend_tgt_q    <= 32'h0;
            pend_jr_q     <= 1'b0;
            redir_q       <= 1'b0;
            addr_err_q    <= 1'b0;
            fetch_count_q <= 32'h0;
        end else begin
            addr_err_q <= 1'b0;
            case (state_q)
                StRun: begin
                    if (!Stall) begin
                        pc_q          <= next_pc;
                        addr_err_q    <= apply_misaligned;
                        fetch_count_q <= fetch_count_q + 32'd1;
                    end else if (req_valid) begin
                        pend_tgt_q <= req_tgt;
                        pend_jr_q  <= req_jr;
                        redir_q    <= 1'b1;
                        state_q    <= StHold;
                    end
                end
                StHold: begin
                    if (Stall) begin
                        if (req_valid) begin
                            pend_tgt_q <= req_tgt;
                            pend_jr_q  <= req_jr;
                        end
                    end else begin
                        pc_q          <= next_pc;
                        addr_err_q    <= apply_misaligned;
                        fetch_count_q <= fetch_count_q + 32'd1;
                        redir_q       <= 1'b0;
                        state_q       <= StRun;
                    end
                end
                default: state_q <= StRun;
            endcase
        end
    end

    assign PC           = pc_q;
    assign RedirPending = redir_q;
    assign AddrErr      = addr_err_q;
    assign FetchCount   = fetch_count_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed bench for pc_branch_unit; expectations adapt to whether PC_JUMP_EN is defined.
module tb_pc_branch_unit;

    logic        Clk;
    logic        Rst;
    logic        Stall;
    logic        BranchTaken;
    logic [31:0] SignExtImm;
    logic [31:0] PCPlus4_ID;
    logic        Jump;
    logic [25:0] JumpIdx;
    logic        JumpReg;
    logic [31:0] RegTarget;
    logic [31:0] PC;
    logic [31:0] PCPlus4;
    logic        RedirPending;
    logic        AddrErr;
    logic [31:0] FetchCount;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] exp_pc;
    logic [31:0] exp_fc;

    pc_branch_unit dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .Stall        (Stall),
        .BranchTaken  (BranchTaken),
        .SignExtImm   (SignExtImm),
        .PCPlus4_ID   (PCPlus4_ID),
        .Jump         (Jump),
        .JumpIdx      (JumpIdx),
        .JumpReg      (JumpReg),
        .RegTarget    (RegTarget),
        .PC           (PC),
        .PCPlus4      (PCPlus4),
        .RedirPending (RedirPending),
        .AddrErr      (AddrErr),
        .FetchCount   (FetchCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_reqs();
        BranchTaken = 1'b0;
        Jump        = 1'b0;
        JumpReg     = 1'b0;
    endtask

    initial begin
        Rst = 1'b1;
        Stall = 1'b0;
        BranchTaken = 1'b0;
        SignExtImm = 32'h0;
        PCPlus4_ID = 32'h0;
        Jump = 1'b0;
        JumpIdx = 26'h0;
        JumpReg = 1'b0;
        RegTarget = 32'h0;

        // Reset state
        step();
        step();
        check_eq("rst_pc", PC, 32'h0);
        check_eq("rst_pcplus4", PCPlus4, 32'h4);
        check_eq("rst_redir", {31'h0, RedirPending}, 32'h0);
        check_eq("rst_addrerr", {31'h0, AddrErr}, 32'h0);
        check_eq("rst_fc", FetchCount, 32'h0);

        // Sequential fetch
        Rst = 1'b0;
        step();
        check_eq("seq_pc1", PC, 32'h4);
        check_eq("seq_fc1", FetchCount, 32'd1);
        step();
        check_eq("seq_pc2", PC, 32'h8);
        check_eq("seq_fc2", FetchCount, 32'd2);
        step();
        check_eq("seq_pc3", PC, 32'hC);
        check_eq("seq_fc3", FetchCount, 32'd3);

        // Backward and forward branches
        PCPlus4_ID = 32'h100;
        SignExtImm = 32'hFFFF_FFFC;
        BranchTaken = 1'b1;
        step();
        check_eq("br_back_pc", PC, 32'hF0);
        check_eq("br_back_fc", FetchCount, 32'd4);
        SignExtImm = 32'h0000_0010;
        step();
        check_eq("br_fwd_pc", PC, 32'h140);
        check_eq("br_fwd_fc", FetchCount, 32'd5);

        // Redirect buffered under stall
        Stall = 1'b1;
        PCPlus4_ID = 32'h200;
        SignExtImm = 32'h0;
        step();
        clear_reqs();
        check_eq("hold_pc0", PC, 32'h140);
        check_eq("hold_redir0", {31'h0, RedirPending}, 32'h1);
        step();
        step();
        check_eq("hold_pc2", PC, 32'h140);
        check_eq("hold_redir2", {31'h0, RedirPending}, 32'h1);
        check_eq("hold_fc2", FetchCount, 32'd5);
        Stall = 1'b0;
        step();
        check_eq("release_pc", PC, 32'h200);
        check_eq("release_redir", {31'h0, RedirPending}, 32'h0);
        check_eq("release_fc", FetchCount, 32'd6);

        // Newest buffered redirect wins
        Stall = 1'b1;
        PCPlus4_ID = 32'h300;
        BranchTaken = 1'b1;
        step();
        PCPlus4_ID = 32'h400;
        step();
        clear_reqs();
        Stall = 1'b0;
        step();
        check_eq("newest_pc", PC, 32'h400);
        check_eq("newest_fc", FetchCount, 32'd7);

        // Jump beats branch in the same cycle
        PCPlus4_ID = 32'h1000_0004;
        SignExtImm = 32'h10;
        JumpIdx = 26'h40;
        Jump = 1'b1;
        BranchTaken = 1'b1;
        step();
        clear_reqs();
`ifdef PC_JUMP_EN
        exp_pc = 32'h1000_0100;
`else
        exp_pc = 32'h1000_0044;
`endif
        check_eq("jump_prio_pc", PC, exp_pc);
        check_eq("jump_prio_fc", FetchCount, 32'd8);

        // Misaligned JumpReg applied directly
        RegTarget = 32'h302;
        JumpReg = 1'b1;
        step();
        clear_reqs();
`ifdef PC_JUMP_EN
        exp_pc = 32'h0000_8000;
        check_eq("jr_mis_addrerr", {31'h0, AddrErr}, 32'h1);
`else
        exp_pc = exp_pc + 32'd4;
        check_eq("jr_mis_addrerr", {31'h0, AddrErr}, 32'h0);
`endif
        check_eq("jr_mis_pc", PC, exp_pc);
        step();
        check_eq("jr_mis_pulse_end", {31'h0, AddrErr}, 32'h0);
        check_eq("jr_mis_next_pc", PC, exp_pc + 32'd4);
        exp_pc = exp_pc + 32'd4;
        check_eq("jr_mis_fc", FetchCount, 32'd10);

        // Buffered misaligned JumpReg is checked when applied
        Stall = 1'b1;
        RegTarget = 32'h502;
        JumpReg = 1'b1;
        step();
        clear_reqs();
`ifdef PC_JUMP_EN
        check_eq("jr_buf_redir", {31'h0, RedirPending}, 32'h1);
`else
        check_eq("jr_buf_redir", {31'h0, RedirPending}, 32'h0);
`endif
        check_eq("jr_buf_addrerr0", {31'h0, AddrErr}, 32'h0);
        Stall = 1'b0;
        step();
`ifdef PC_JUMP_EN
        check_eq("jr_buf_pc", PC, 32'h0000_8000);
        check_eq("jr_buf_addrerr1", {31'h0, AddrErr}, 32'h1);
`else
        check_eq("jr_buf_pc", PC, exp_pc + 32'd4);
        check_eq("jr_buf_addrerr1", {31'h0, AddrErr}, 32'h0);
`endif

        // Reset during HOLD discards the buffered redirect
        Stall = 1'b1;
        PCPlus4_ID = 32'h600;
        SignExtImm = 32'h0;
        BranchTaken = 1'b1;
        step();
        clear_reqs();
        check_eq("rsthold_redir0", {31'h0, RedirPending}, 32'h1);
        Rst = 1'b1;
        step();
        check_eq("rsthold_pc", PC, 32'h0);
        check_eq("rsthold_redir", {31'h0, RedirPending}, 32'h0);
        check_eq("rsthold_fc", FetchCount, 32'h0);
        Rst = 1'b0;
        Stall = 1'b0;
        step();
        check_eq("rsthold_after_pc", PC, 32'h4);
        check_eq("rsthold_after_fc", FetchCount, 32'd1);

        // PC and FetchCount wraparound
        PCPlus4_ID = 32'h0;
        SignExtImm = 32'hFFFF_FFFF;
        BranchTaken = 1'b1;
        step();
        clear_reqs();
        check_eq("wrap_pc_top", PC, 32'hFFFF_FFFC);
        check_eq("wrap_pcplus4", PCPlus4, 32'h0);
        exp_fc = 32'hFFFF_FFFF;
        force dut.fetch_count_q = exp_fc;
        #1;
        release dut.fetch_count_q;
        #1;
        check_eq("wrap_fc_preload", FetchCount, exp_fc);
        step();
        check_eq("wrap_pc", PC, 32'h0);
        check_eq("wrap_fc", FetchCount, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
